// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg -- shared PS/2 state encoding, frame sizes and parity helper
// Rev 1.0
// ============================================================================
package ps2_pkg;

    localparam int FRAME_BITS = 11;   // start, 8 data, parity, stop
    localparam int RX_BITS    = 10;   // 8 data, parity, stop (start is the RTS)
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX_HI  = 3'd1,
        ST_TX_LO  = 3'd2,
        ST_ABORT  = 3'd3,
        ST_RX_REQ = 3'd4,
        ST_RX_LO  = 3'd5,
        ST_RX_HI  = 3'd6,
        ST_RX_ACK = 3'd7
    } ps2_state_e;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_dev_fifo.sv
`default_nettype none
// ============================================================================
// ps2_dev_fifo -- 4 x 8 synchronous FIFO holding bytes queued for the host
// Rev 1.0
// ============================================================================
module ps2_dev_fifo
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = FIFO_DEPTH[c_PTR_W:0];

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_q;
    logic [c_PTR_W-1:0] rd_q;
    logic [c_PTR_W:0]   cnt_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (cnt_q == c_FULL);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{c_PTR_W{1'b0}}, do_push} - {{c_PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_dev.sv
`default_nettype none
// ============================================================================
// ps2_dev -- PS/2 device-side port: sources the PS/2 clock, sends queued bytes
//            to the host and receives host commands with line acknowledge
// Rev 1.0
// ============================================================================
module ps2_dev
    import ps2_pkg::*;
#(
    parameter int HALF_PER = 1200,
    parameter int IDLE_HP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parerr,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int                  c_CNT_W     = $clog2(HALF_PER);
    localparam int                  c_IDLE_W    = $clog2(IDLE_HP + 2);
    localparam logic [c_CNT_W-1:0]  c_HP_RELOAD = c_CNT_W'(HALF_PER - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_SAT  = c_IDLE_W'(IDLE_HP);

    logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

    ps2_state_e          state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [c_IDLE_W-1:0] idle_q, idle_d;
    logic [3:0]          bit_q, bit_d;
    logic                ack_ph_q, ack_ph_d;
    logic [RX_BITS-1:0]  rx_sh_q, rx_sh_d;
    logic                rx_done, rx_done_q;
    logic [7:0]          rx_data_q;
    logic                rx_parerr_q, rx_valid_q;

    logic                   hp_done, lines_idle;
    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [7:0]             fifo_head;
    logic [FRAME_BITS-1:0]  tx_frame;

    ps2_dev_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_frame   = {1'b1, odd_parity(fifo_head), fifo_head, 1'b0};
    assign hp_done    = (cnt_q == '0);
    assign lines_idle = clk_sync_q & dat_sync_q;

    // Pins idle high, so the synchronizers reset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= c_HP_RELOAD;
            idle_q   <= '0;
            bit_q    <= '0;
            ack_ph_q <= 1'b0;
            rx_sh_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            bit_q    <= bit_d;
            ack_ph_q <= ack_ph_d;
            rx_sh_q  <= rx_sh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        bit_d    = bit_q;
        ack_ph_d = ack_ph_q;
        rx_sh_d  = rx_sh_q;
        fifo_pop = 1'b0;
        rx_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!lines_idle)                         idle_d = '0;
                else if (hp_done && idle_q < c_IDLE_SAT) idle_d = idle_q + 1'b1;
                if (clk_sync_q && !dat_sync_q) begin
                    state_d = ST_RX_REQ;
                end else if (!fifo_empty && idle_q >= c_IDLE_SAT) begin
                    state_d = ST_TX_HI;
                    bit_d   = '0;
                end
            end
            ST_TX_HI: begin
                if (hp_done) state_d = clk_sync_q ? ST_TX_LO : ST_ABORT;
            end
            ST_TX_LO: begin
                if (hp_done) begin
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = ST_TX_HI;
                    end
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            ST_RX_REQ: begin
                if (hp_done) begin
                    state_d = ST_RX_LO;
                    bit_d   = '0;
                end
            end
            ST_RX_LO: begin
                if (hp_done) state_d = ST_RX_HI;
            end
            ST_RX_HI: begin
                if (hp_done) begin
                    rx_sh_d = {dat_sync_q, rx_sh_q[RX_BITS-1:1]};
                    if (bit_q == 4'(RX_BITS - 1)) begin
                        state_d  = ST_RX_ACK;
                        ack_ph_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = ST_RX_LO;
                    end
                end
            end
            ST_RX_ACK: begin
                if (hp_done) begin
                    if (!ack_ph_q) begin
                        ack_ph_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        rx_done = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Idle qualification restarts after every frame or abort.
        if (state_q != ST_IDLE) idle_d = '0;

        if (state_d != state_q || hp_done || (state_q == ST_IDLE && !lines_idle))
            cnt_d = c_HP_RELOAD;
        else
            cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        case (state_q)
            ST_TX_HI:  ps2_dat_oe = ~tx_frame[bit_q];
            ST_TX_LO: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = ~tx_frame[bit_q];
            end
            ST_RX_LO:  ps2_clk_oe = 1'b1;
            ST_RX_ACK: begin
                ps2_dat_oe = 1'b1;
                ps2_clk_oe = ack_ph_q;
            end
            default: begin
                ps2_clk_oe = 1'b0;
                ps2_dat_oe = 1'b0;
            end
        endcase
    end

    // The received byte is published one cycle after the ack clock is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_parerr_q <= 1'b0;
        end else begin
            rx_done_q  <= rx_done;
            rx_valid_q <= rx_done_q;
            if (rx_done_q) begin
                rx_data_q   <= rx_sh_q[7:0];
                rx_parerr_q <= ~(^rx_sh_q[8:0]) | ~rx_sh_q[9];
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_parerr = rx_parerr_q;
    assign tx_ready  = ~fifo_full;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_dev.sv
`default_nettype none
// ============================================================================
// tb_ps2_dev -- directed self-checking bench; the bench plays the PS/2 host
// Rev 1.0
// ============================================================================
module tb_ps2_dev;
    localparam int HP  = 16;
    localparam int IHP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parerr;
    logic       busy;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       host_clk_pull = 1'b0;
    logic       host_dat_pull = 1'b0;

    int errors = 0;
    int checks = 0;

    // Open-drain wired-AND of device and host drivers.
    assign ps2_clk_in = ~(ps2_clk_oe | host_clk_pull);
    assign ps2_dat_in = ~(ps2_dat_oe | host_dat_pull);

    ps2_dev #(.HALF_PER(HP), .IDLE_HP(IHP)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_parerr  (rx_parerr),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    // Lengths of the most recent busy run and of the idle gap preceding a frame.
    int   busy_run = 0, last_busy_run = 0, idle_run = 0, last_idle_gap = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run <= 0;
            idle_run <= 0;
        end else if (busy) begin
            busy_run <= busy_run + 1;
            idle_run <= 0;
            if (!busy_prev) last_idle_gap <= idle_run;
        end else begin
            idle_run <= idle_run + 1;
            busy_run <= 0;
            if (busy_prev) last_busy_run <= busy_run;
        end
        busy_prev <= busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_clk_line(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ps2_clk_in == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Samples the data line at each falling edge of the PS/2 clock.
    task automatic capture_frame(output logic [10:0] bits, output bit ok);
        bit o;
        ok   = 1'b1;
        bits = '0;
        for (int i = 0; i < 11; i++) begin
            wait_clk_line(1'b0, 200 * HP, o);
            if (!o) begin ok = 1'b0; return; end
            bits[i] = ps2_dat_in;
            wait_clk_line(1'b1, 4 * HP, o);
            if (!o) begin ok = 1'b0; return; end
        end
    endtask

    task automatic count_busy(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy) n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
        repeat (4) @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_parerr !== 1'b0) begin errors++; $display("FAIL reset_rx_parerr: got %b want 0", rx_parerr); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx_1c();
        logic [10:0] bits;
        bit          ok;
        int          n;
        push_byte(8'h1C);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx1c_ready: got %b want 1", tx_ready); end
        capture_frame(bits, ok);
        checks++; if (!ok || bits !== 11'b100_0011_1000) begin errors++; $display("FAIL tx1c_frame: got %b (complete=%0d) want 10000111000", bits, ok); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tx1c_busy_end: got %b want 0", busy); end
        checks++; if (last_busy_run != 22 * HP) begin errors++; $display("FAIL tx1c_frame_len: got %0d want %0d cycles", last_busy_run, 22 * HP); end
        count_busy((IHP + 3) * HP, n);
        checks++; if (n != 0) begin errors++; $display("FAIL tx1c_fifo_empty: got %0d busy cycles want 0", n); end
    endtask

    task automatic test_rx(input string tag, input logic [7:0] b, input logic par, input logic stop,
                           input logic exp_err);
        logic [9:0] bits;
        bit         o, all_ok;
        bits   = {stop, par, b};
        all_ok = 1'b1;
        @(negedge clk);
        host_clk_pull = 1'b1;
        repeat (2 * HP) @(negedge clk);
        host_dat_pull = 1'b1;
        @(negedge clk);
        host_clk_pull = 1'b0;
        for (int i = 0; i < 10 && all_ok; i++) begin
            wait_clk_line(1'b0, 4 * HP, o);
            if (!o) all_ok = 1'b0;
            host_dat_pull = ~bits[i];
            wait_clk_line(1'b1, 4 * HP, o);
            if (!o) all_ok = 1'b0;
        end
        if (all_ok) begin
            wait_clk_line(1'b0, 4 * HP, o);
            if (!o) all_ok = 1'b0;
        end
        host_dat_pull = 1'b0;
        checks++; if (!all_ok) begin errors++; $display("FAIL %s_clocks: device clock pulses missing, got timeout want 11 pulses", tag); return; end
        checks++; if (ps2_dat_in !== 1'b0) begin errors++; $display("FAIL %s_ack: data line got %b want 0 on 11th clock", tag, ps2_dat_in); end
        wait_clk_line(1'b1, 4 * HP, o);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1 one cycle after ack release", tag, rx_valid); end
        checks++; if (rx_data !== b) begin errors++; $display("FAIL %s_data: got %h want %h", tag, rx_data, b); end
        checks++; if (rx_parerr !== exp_err) begin errors++; $display("FAIL %s_parerr: got %b want %b", tag, rx_parerr, exp_err); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_pulse: got %b want 0", tag, rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
        repeat (2 * HP) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [10:0] bits;
        bit          o, all_ok;
        int          n;
        all_ok = 1'b1;
        push_byte(8'hAA);
        for (int i = 0; i < 4 && all_ok; i++) begin
            wait_clk_line(1'b0, 200 * HP, o);
            if (!o) all_ok = 1'b0;
            wait_clk_line(1'b1, 4 * HP, o);
            if (!o) all_ok = 1'b0;
        end
        host_clk_pull = 1'b1;
        checks++; if (!all_ok) begin errors++; $display("FAIL abort_start: got timeout want 4 clock pulses"); end
        repeat (HP + 4) @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL abort_clk_oe: got %b want 0", ps2_clk_oe); end
        checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL abort_dat_oe: got %b want 0", ps2_dat_oe); end
        count_busy(2 * HP, n);
        checks++; if (n != 0) begin errors++; $display("FAIL abort_inhibit_busy: got %0d busy cycles want 0", n); end
        host_clk_pull = 1'b0;
        capture_frame(bits, o);
        checks++; if (!o || bits !== 11'b111_0101_0100) begin errors++; $display("FAIL abort_resend: got %b (complete=%0d) want 11101010100", bits, o); end
        count_busy((IHP + 3) * HP, n);
        checks++; if (n != 0) begin errors++; $display("FAIL abort_single_resend: got %0d busy cycles want 0", n); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_f [4];
        logic [10:0] bits;
        logic [4:0]  rdy;
        bit          o;
        int          n;
        exp_f[0] = 11'b100_0000_0010;
        exp_f[1] = 11'b100_0000_0100;
        exp_f[2] = 11'b110_0000_0110;
        exp_f[3] = 11'b100_0000_1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tx_data  = 8'(k + 1);
            tx_valid = 1'b1;
            rdy[k]   = tx_ready;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (rdy[3:0] !== 4'hF) begin errors++; $display("FAIL b2b_ready_first4: got %b want 1111", rdy[3:0]); end
        checks++; if (rdy[4] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", rdy[4]); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after: got %b want 0", tx_ready); end
        for (int f = 0; f < 4; f++) begin
            capture_frame(bits, o);
            checks++; if (!o || bits !== exp_f[f]) begin errors++; $display("FAIL b2b_frame%0d: got %b (complete=%0d) want %b", f, bits, o, exp_f[f]); end
            if (f > 0) begin
                checks++; if (last_idle_gap < IHP * HP) begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles want >= %0d", f, last_idle_gap, IHP * HP); end
            end
        end
        count_busy((IHP + 3) * HP, n);
        checks++; if (n != 0) begin errors++; $display("FAIL b2b_drop5: got %0d busy cycles want 0", n); end
    endtask

    task automatic test_reset_mid_tx();
        bit o, all_ok;
        int lows;
        all_ok = 1'b1;
        push_byte(8'h55);
        push_byte(8'h66);
        for (int i = 0; i < 6 && all_ok; i++) begin
            wait_clk_line(1'b0, 200 * HP, o);
            if (!o) all_ok = 1'b0;
            wait_clk_line(1'b1, 4 * HP, o);
            if (!o) all_ok = 1'b0;
        end
        if (all_ok) begin
            wait_clk_line(1'b0, 4 * HP, o);
            if (!o) all_ok = 1'b0;
        end
        checks++; if (!all_ok || ps2_dat_oe !== 1'b1) begin errors++; $display("FAIL rstmid_bit6: dat_oe got %b (complete=%0d) want 1", ps2_dat_oe, all_ok); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL rstmid_clk_oe: got %b want 0", ps2_clk_oe); end
        checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL rstmid_dat_oe: got %b want 0", ps2_dat_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (rx_data !== 8'h00 || rx_parerr !== 1'b0) begin errors++; $display("FAIL rstmid_rx_regs: got data=%h parerr=%b want 00/0", rx_data, rx_parerr); end
        rst = 1'b0;
        lows = 0;
        repeat (20 * HP) begin
            @(negedge clk);
            if (ps2_clk_oe) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_no_clock: got %0d clock-low cycles want 0", lows); end
    endtask

    initial begin
        test_reset();
        test_tx_1c();
        test_rx("rx_ff", 8'hFF, 1'b1, 1'b1, 1'b0);
        test_rx("rx_f0_badpar", 8'hF0, 1'b0, 1'b1, 1'b1);
        test_rx("rx_3c_badstop", 8'h3C, 1'b1, 1'b0, 1'b1);
        test_abort();
        test_back_to_back();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
